// File: rtl/m_dm_if.sv
// MEM-stage data memory bus: address/data/op controls in, raw word, faults and write trace out.
// The master drives the access; the slave is the memory.
interface m_dm_if;
  logic [31:0] A;
  logic [31:0] WD;
  logic [1:0]  BEOp;
  logic [3:0]  DEOp;
  logic [31:0] DMO;
  logic        ExcAdEL;
  logic        ExcAdES;
  logic        ExcSticky;
  logic        WrValid;
  logic [31:0] WrAddr;
  logic [31:0] WrData;

  modport master (
    output A, WD, BEOp, DEOp,
    input  DMO, ExcAdEL, ExcAdES, ExcSticky, WrValid, WrAddr, WrData
  );

  modport slave (
    input  A, WD, BEOp, DEOp,
    output DMO, ExcAdEL, ExcAdES, ExcSticky, WrValid, WrAddr, WrData
  );
endinterface

// File: rtl/m_dm.sv
// MEM-stage data memory: byte-enable stores, raw aligned word reads, alignment/range faults.
// Reads are combinational; stores commit on the clock edge and are traced one cycle later.
module m_dm #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input logic   clk,
  input logic   reset,
  m_dm_if.slave bus
);

  logic [31:0]       r_mem [DEPTH];
  logic              r_sticky;
  logic              r_wr_vld;
  logic [31:0]       r_wr_addr;
  logic [31:0]       r_wr_dat;

  logic              w_oor;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_old;
  logic [3:0]        w_be;
  logic [31:0]       w_lane;
  logic [31:0]       w_merged;
  logic              w_st_mis;
  logic              w_ld_mis;
  logic              w_exc_es;
  logic              w_exc_el;
  logic              w_commit;

  assign w_oor = |bus.A[31:ADDR_W+2];
  assign w_idx = bus.A[ADDR_W+1:2];
  assign w_old = r_mem[w_idx];

  assign w_st_mis = (bus.BEOp == 2'd1 && bus.A[1:0] != 2'b00) ||
                    (bus.BEOp == 2'd2 && bus.A[0]);
  assign w_ld_mis = (bus.DEOp == 4'd0 && bus.A[1:0] != 2'b00) ||
                    (bus.DEOp == 4'd1 && bus.A[0]);

  assign w_exc_es = (bus.BEOp != 2'd0) && (w_oor || w_st_mis);
  assign w_exc_el = (bus.DEOp != 4'd15) && (w_oor || w_ld_mis);
  assign w_commit = (bus.BEOp != 2'd0) && !w_exc_es;

  always_comb begin
    w_be   = 4'b0000;
    w_lane = bus.WD;
    case (bus.BEOp)
      2'd1: w_be = 4'b1111;
      2'd2: begin
        w_be   = bus.A[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{bus.WD[15:0]}};
      end
      2'd3: begin
        w_be   = 4'b0001 << bus.A[1:0];
        w_lane = {4{bus.WD[7:0]}};
      end
      default: w_be = 4'b0000;
    endcase
  end

  // Disabled lanes keep the stored bytes so the trace carries the full new word.
  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[8*b +: 8] = w_lane[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
      r_sticky  <= 1'b0;
      r_wr_vld  <= 1'b0;
      r_wr_addr <= 32'd0;
      r_wr_dat  <= 32'd0;
    end else begin
      if (w_commit) begin
        r_mem[w_idx] <= w_merged;
        r_wr_addr    <= {bus.A[31:2], 2'b00};
        r_wr_dat     <= w_merged;
      end
      r_wr_vld <= w_commit;
      if (w_exc_es || w_exc_el) r_sticky <= 1'b1;
    end
  end

  assign bus.DMO       = w_oor ? 32'd0 : w_old;
  assign bus.ExcAdEL   = w_exc_el;
  assign bus.ExcAdES   = w_exc_es;
  assign bus.ExcSticky = r_sticky;
  assign bus.WrValid   = r_wr_vld;
  assign bus.WrAddr    = r_wr_addr;
  assign bus.WrData    = r_wr_dat;

endmodule

// File: tb/tb_m_dm.sv
// Bench for m_dm: vector table with a trace scoreboard, plus extender and mid-burst reset sequences.
module tb_m_dm;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  m_dm_if bus ();

  m_dm #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  be;
    logic [3:0]  de;
    logic [31:0] dmo;
    logic        el;
    logic        es;
    logic        sticky;
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wdat;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
  } trc_t;

  vec_t tbl[$];
  trc_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] be, input logic [3:0] de);
    bus.A    = a;
    bus.WD   = wd;
    bus.BEOp = be;
    bus.DEOp = de;
  endtask

  task automatic check_trace();
    trc_t t;
    if (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      chk("WrValid", {31'd0, bus.WrValid}, {31'd0, t.v});
      if (t.v) begin
        chk("WrAddr", bus.WrAddr, t.a);
        chk("WrData", bus.WrData, t.d);
      end
    end
  endtask

  function automatic vec_t mk(logic [31:0] a, logic [31:0] wd, logic [1:0] be, logic [3:0] de,
                              logic [31:0] dmo, logic el, logic es, logic st,
                              logic wv, logic [31:0] wa, logic [31:0] wdat);
    vec_t v;
    v.a = a; v.wd = wd; v.be = be; v.de = de;
    v.dmo = dmo; v.el = el; v.es = es; v.sticky = st;
    v.wv = wv; v.wa = wa; v.wdat = wdat;
    return v;
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] ext;

    //      A             WD            BE    DE     DMO           EL    ES    STK   WV    WA      WDAT
    tbl.push_back(mk(32'h0,        32'h0,        2'd0, 4'd15, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'hFFC,      32'h0,        2'd0, 4'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h10,       32'h12345678, 2'd1, 4'd15, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h12345678));
    tbl.push_back(mk(32'h11,       32'h000000AB, 2'd3, 4'd15, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h1234AB78));
    tbl.push_back(mk(32'h10,       32'h0,        2'd0, 4'd0,  32'h1234AB78, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h22,       32'h0000BEEF, 2'd2, 4'd15, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hBEEF0000));
    tbl.push_back(mk(32'h22,       32'h0,        2'd0, 4'd1,  32'hBEEF0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h13,       32'hFFFFFFFF, 2'd1, 4'd15, 32'h1234AB78, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h10,       32'h0,        2'd0, 4'd0,  32'h1234AB78, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h1000,     32'h0,        2'd0, 4'd0,  32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h13,       32'h0,        2'd0, 4'd2,  32'h1234AB78, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h21,       32'h00000001, 2'd2, 4'd15, 32'hBEEF0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h23,       32'h00000011, 2'd3, 4'd15, 32'hBEEF0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h11EF0000));
    tbl.push_back(mk(32'h20,       32'hFFFF2222, 2'd2, 4'd15, 32'h11EF0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h11EF2222));
    tbl.push_back(mk(32'h1004,     32'h00000005, 2'd1, 4'd15, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h20,       32'h0,        2'd0, 4'd0,  32'h11EF2222, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'hFFC,      32'hCAFEF00D, 2'd1, 4'd15, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hFFC, 32'hCAFEF00D));
    tbl.push_back(mk(32'hFFD,      32'h0,        2'd0, 4'd1,  32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h80000010, 32'h00000055, 2'd3, 4'd15, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0));
    tbl.push_back(mk(32'h10,       32'h0,        2'd0, 4'd0,  32'h1234AB78, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0));

    reset = 1'b0;
    drive(32'h0, 32'h0, 2'd0, 4'd15);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_DMO",    bus.DMO, 32'h0);
    chk("rst_Sticky", {31'd0, bus.ExcSticky}, 32'h0);
    chk("rst_WrValid",{31'd0, bus.WrValid}, 32'h0);
    chk("rst_WrAddr", bus.WrAddr, 32'h0);
    chk("rst_WrData", bus.WrData, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].de);
      @(negedge clk);
      check_trace();
      chk($sformatf("v%0d_DMO", i),    bus.DMO, tbl[i].dmo);
      chk($sformatf("v%0d_ExcAdEL", i), {31'd0, bus.ExcAdEL}, {31'd0, tbl[i].el});
      chk($sformatf("v%0d_ExcAdES", i), {31'd0, bus.ExcAdES}, {31'd0, tbl[i].es});
      chk($sformatf("v%0d_Sticky", i),  {31'd0, bus.ExcSticky}, {31'd0, tbl[i].sticky});
      if (i == 6) begin
        w   = bus.DMO;
        ext = {{16{w[31]}}, w[31:16]};
        chk("lh_ext_off2", ext, 32'hFFFFBEEF);
      end
      sb_q.push_back('{v: tbl[i].wv, a: tbl[i].wa, d: tbl[i].wdat});
      @(posedge clk);
      #1;
    end
    drive(32'h0, 32'h0, 2'd0, 4'd15);
    @(negedge clk);
    check_trace();

    // Reset lands mid-burst of word stores; memory and trace must clear at once.
    @(posedge clk);
    #1 drive(32'h40, 32'h000000A1, 2'd1, 4'd15);
    @(posedge clk);
    #1 drive(32'h44, 32'h000000A2, 2'd1, 4'd15);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_WrValid", {31'd0, bus.WrValid}, 32'h0);
    chk("mid_rst_WrAddr",  bus.WrAddr, 32'h0);
    chk("mid_rst_WrData",  bus.WrData, 32'h0);
    chk("mid_rst_Sticky",  {31'd0, bus.ExcSticky}, 32'h0);
    drive(32'h40, 32'h0, 2'd0, 4'd15);
    #1 chk("mid_rst_w40", bus.DMO, 32'h0);
    drive(32'h10, 32'h0, 2'd0, 4'd15);
    #1 chk("mid_rst_w10", bus.DMO, 32'h0);
    drive(32'h48, 32'h000000A3, 2'd1, 4'd15);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(32'h48, 32'h0, 2'd0, 4'd15);
    @(negedge clk);
    chk("post_rst_w48", bus.DMO, 32'h0);
    chk("post_rst_WrValid", {31'd0, bus.WrValid}, 32'h0);
    drive(32'h40, 32'h00000077, 2'd1, 4'd15);
    @(posedge clk);
    #1 drive(32'h40, 32'h0, 2'd0, 4'd0);
    @(negedge clk);
    chk("first_st_WrValid", {31'd0, bus.WrValid}, 32'h1);
    chk("first_st_WrAddr",  bus.WrAddr, 32'h40);
    chk("first_st_WrData",  bus.WrData, 32'h77);
    chk("first_st_DMO",     bus.DMO, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
